// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator.
// Default timing is 640x480@60 from a 25 MHz pixel clock (800x525 total).
//
// Ports:
//   clk_25      in   pixel clock, all logic on the rising edge
//   reset       in   asynchronous reset, active-high
//   h_count     out  pixel column, 0..H_TOTAL-1
//   v_count     out  line, 0..V_TOTAL-1
//   bright      out  1 inside the visible area
//   hsync       out  horizontal sync, asserted level = SYNC_POL
//   vsync       out  vertical sync, asserted level = SYNC_POL
//   line_start  out  1-cycle pulse when h_count == 0
//   frame_start out  1-cycle pulse when h_count == 0 and v_count == 0
//
// Every output is a flop. The decodes are taken from the next-state counts,
// so they line up with the counts presented in the same cycle.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       clk_25,
  input  logic       reset,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       bright,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = 1'(SYNC_POL);
  localparam logic        SYNC_OFF = ~SYNC_ON;

  // Counters are 10 bits wide, so larger totals cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       bright_q, bright_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap;
  logic [10:0] h_ext, v_ext;

  // Next counts, then every decode from those next counts.
  always_comb begin
    h_wrap    = (h_count_q == 10'(H_TOTAL - 1));
    h_count_d = h_wrap ? 10'd0 : h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = (v_count_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_count_q + 10'd1;
    end

    h_ext = {1'b0, h_count_d};
    v_ext = {1'b0, v_count_d};

    bright_d      = (h_ext < 11'(H_VISIBLE)) && (v_ext < 11'(V_VISIBLE));
    hsync_d       = ((h_ext >= 11'(HS_START)) && (h_ext < 11'(HS_END))) ? SYNC_ON : SYNC_OFF;
    vsync_d       = ((v_ext >= 11'(VS_START)) && (v_ext < 11'(VS_END))) ? SYNC_ON : SYNC_OFF;
    line_start_d  = (h_count_d == 10'd0);
    frame_start_d = (h_count_d == 10'd0) && (v_count_d == 10'd0);
  end

  // Reset parks the counts on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      h_count_q     <= 10'(H_TOTAL - 1);
      v_count_q     <= 10'(V_TOTAL - 1);
      bright_q      <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      bright_q      <= bright_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign bright      = bright_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
// u_dflt uses the default 800x525 timing (first 11 lines plus a mid-line reset);
// u_small uses a 15x10 raster with active-high syncs so a whole frame is cheap.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst0, rst1;
  logic [9:0] h0, v0, h1, v1;
  logic       b0, hs0, vs0, ls0, fs0;
  logic       b1, hs1, vs1, ls1, fs1;

  int vectors     = 0;
  int miscompares = 0;

  vga_sync_gen u_dflt (
    .clk_25(clk), .reset(rst0),
    .h_count(h0), .v_count(v0), .bright(b0), .hsync(hs0), .vsync(vs0),
    .line_start(ls0), .frame_start(fs0)
  );

  // H: 8 visible, 2 front, 3 sync, 2 back = 15.  V: 6, 1, 2, 1 = 10.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1)
  ) u_small (
    .clk_25(clk), .reset(rst1),
    .h_count(h1), .v_count(v1), .bright(b1), .hsync(hs1), .vsync(vs1),
    .line_start(ls1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int   ls_cnt, fs_cnt, br_cnt, run, last_ls, hlow10, br_in_hs, vlow;
  int   hs_hi, vs_hi, hs_in_vs;
  logic prev_b, prev_hs, prev_vs;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, default timing
    chk("rst_h", 32'(h0), 799);
    chk("rst_v", 32'(v0), 524);
    chk("rst_bright", 32'(b0), 0);
    chk("rst_hsync", 32'(hs0), 1);
    chk("rst_vsync", 32'(vs0), 1);
    chk("rst_ls", 32'(ls0), 0);
    chk("rst_fs", 32'(fs0), 0);

    rst0 = 1'b0;
    step();
    chk("first_h", 32'(h0), 0);
    chk("first_v", 32'(v0), 0);
    chk("first_bright", 32'(b0), 1);
    chk("first_ls", 32'(ls0), 1);
    chk("first_fs", 32'(fs0), 1);
    chk("first_hsync", 32'(hs0), 1);

    // Lines 0..10 of the default raster
    ls_cnt = 0; fs_cnt = 0; br_cnt = 0; run = 0; last_ls = -1;
    hlow10 = 0; br_in_hs = 0; vlow = 0;
    prev_b = 1'b0; prev_hs = 1'b1;
    for (int t = 0; t < 800 * 11; t++) begin
      if (ls0) begin
        if (last_ls >= 0) chk("ls_interval", t - last_ls, 800);
        last_ls = t;
        ls_cnt++;
      end
      if (fs0) fs_cnt++;
      if (b0 && !prev_b) begin
        chk("bright_rise_h", 32'(h0), 0);
        run = 0;
      end
      if (b0) begin
        run++;
        br_cnt++;
      end
      if (!b0 && prev_b) chk("bright_run_len", run, 640);
      if (v0 == 10'd10) begin
        if (!hs0 && prev_hs) chk("hs_fall_h", 32'(h0), 656);
        if (hs0 && !prev_hs) chk("hs_rise_h", 32'(h0), 752);
        if (!hs0) hlow10++;
        if (!hs0 && b0) br_in_hs++;
      end
      if (!vs0) vlow++;
      prev_b  = b0;
      prev_hs = hs0;
      step();
    end
    chk("ls_count_11_lines", ls_cnt, 11);
    chk("fs_count_11_lines", fs_cnt, 1);
    chk("bright_count_11_lines", br_cnt, 7040);
    chk("hsync_low_line10", hlow10, 96);
    chk("bright_during_hsync", br_in_hs, 0);
    chk("vsync_low_early", vlow, 0);
    chk("line11_h", 32'(h0), 0);
    chk("line11_v", 32'(v0), 11);

    // Reset in the middle of a visible line
    repeat (400) step();
    chk("pre_reset_h", 32'(h0), 400);
    chk("pre_reset_bright", 32'(b0), 1);
    rst0 = 1'b1;
    #1;
    chk("midrst_h", 32'(h0), 799);
    chk("midrst_v", 32'(v0), 524);
    chk("midrst_bright", 32'(b0), 0);
    chk("midrst_hsync", 32'(hs0), 1);
    chk("midrst_vsync", 32'(vs0), 1);
    chk("midrst_fs", 32'(fs0), 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("inrst_h", 32'(h0), 799);
      chk("inrst_fs", 32'(fs0), 0);
    end
    rst0 = 1'b0;
    step();
    chk("restart_h", 32'(h0), 0);
    chk("restart_v", 32'(v0), 0);
    chk("restart_fs", 32'(fs0), 1);
    chk("restart_bright", 32'(b0), 1);

    // Small raster, active-high syncs
    chk("small_rst_h", 32'(h1), 14);
    chk("small_rst_v", 32'(v1), 9);
    chk("small_rst_hsync", 32'(hs1), 0);
    chk("small_rst_vsync", 32'(vs1), 0);
    chk("small_rst_bright", 32'(b1), 0);
    rst1 = 1'b0;
    step();
    chk("small_first_fs", 32'(fs1), 1);

    ls_cnt = 0; fs_cnt = 0; br_cnt = 0; run = 0;
    hs_hi = 0; vs_hi = 0; hs_in_vs = 0;
    prev_b = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0;
    for (int t = 0; t < 150; t++) begin
      if (ls1) ls_cnt++;
      if (fs1) fs_cnt++;
      if (b1 && !prev_b) begin
        chk("small_bright_rise_h", 32'(h1), 0);
        run = 0;
      end
      if (b1) begin
        run++;
        br_cnt++;
      end
      if (!b1 && prev_b) chk("small_bright_run_len", run, 8);
      if (v1 == 10'd0) begin
        if (h1 == 10'd9)  chk("small_hs_h9", 32'(hs1), 0);
        if (h1 == 10'd10) chk("small_hs_h10", 32'(hs1), 1);
        if (h1 == 10'd12) chk("small_hs_h12", 32'(hs1), 1);
        if (h1 == 10'd13) chk("small_hs_h13", 32'(hs1), 0);
      end
      if (vs1 && !prev_vs) begin
        chk("small_vs_rise_v", 32'(v1), 7);
        chk("small_vs_rise_h", 32'(h1), 0);
      end
      if (!vs1 && prev_vs) begin
        chk("small_vs_fall_v", 32'(v1), 9);
        chk("small_vs_fall_h", 32'(h1), 0);
      end
      if (hs1) hs_hi++;
      if (vs1) vs_hi++;
      if (vs1 && hs1 && !prev_hs) hs_in_vs++;
      prev_b  = b1;
      prev_hs = hs1;
      prev_vs = vs1;
      step();
    end
    chk("small_ls_per_frame", ls_cnt, 10);
    chk("small_fs_per_frame", fs_cnt, 1);
    chk("small_bright_count", br_cnt, 48);
    chk("small_hsync_high", hs_hi, 30);
    chk("small_vsync_high", vs_hi, 30);
    chk("small_hs_pulses_in_vs", hs_in_vs, 2);
    chk("small_wrap_fs", 32'(fs1), 1);
    chk("small_wrap_h", 32'(h1), 0);
    chk("small_wrap_v", 32'(v1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
